contador_bcd_mux: RTL and testbench

Parametrised multi-digit BCD up/down counter with a multiplexed 7-segment display driver. It is the successor to the single-digit 0–9 counter. It divides the board clock to a count tick and holds `DIGITS` BCD digits. It counts up or down with wrap and carry/borrow, and time-multiplexes the digits onto one shared segment bus plus one anode line per digit. It sits directly between the board clock/switches and the 7-segment display pins.

---
 rtl/contador_bcd_mux_if.sv | 16 +
 rtl/contador_bcd_mux.sv | 139 +++++++++++++
 tb/tb_contador_bcd_mux.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/contador_bcd_mux_if.sv
// Control and display bus of the multi-digit BCD counter.
// There is no valid/ready handshake: En/Up/Clr are level controls sampled on C50, and all display outputs are registered.
interface contador_bcd_mux_if #(
    parameter int DIGITS = 4
);
    logic              En;
    logic              Up;
    logic              Clr;
    logic [6:0]        D;
    logic [DIGITS-1:0] Anodo;
    logic              Tick;
    logic              Carry;

    modport master (output En, Up, Clr, input D, Anodo, Tick, Carry);
    modport slave  (input En, Up, Clr, output D, Anodo, Tick, Carry);
endinterface

// File: rtl/contador_bcd_mux.sv
// Multi-digit BCD up/down counter with a tick prescaler and a time-multiplexed 7-segment driver.
module contador_bcd_mux #(
    parameter int CLK_HZ           = 50_000_000,
    parameter int TICK_HZ          = 1,
    parameter int DIGITS           = 4,
    parameter int SCAN_HZ          = 1000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                C50,
    input  logic                Rst,
    contador_bcd_mux_if.slave   bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int PW       = $clog2(TICK_DIV);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW       = 4 * DIGITS;
    localparam logic [DIGITS-1:0] SEL0   = DIGITS'(1);
    localparam logic [DIGITS-1:0] AN_RST = ANODE_ACTIVE_LOW ? ~SEL0 : SEL0;

    logic [PW-1:0]     p_q, p_d;
    logic [VW-1:0]     val_q, val_d, step_val;
    logic              tick_q, tick_d;
    logic              carry_q, carry_d;
    logic [SW-1:0]     s_q, s_d;
    logic [IW-1:0]     i_q, i_d;
    logic [6:0]        d_q, d_d;
    logic [DIGITS-1:0] anodo_q, anodo_d;
    logic              tick_ev;
    logic              ripple;
    logic [3:0]        dig;
    logic [3:0]        cur_digit;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    // Counting path: the ripple flag survives the loop only if every digit wrapped.
    always_comb begin
        tick_ev  = (p_q == PW'(TICK_DIV - 1));
        p_d      = tick_ev ? '0 : p_q + 1'b1;
        step_val = val_q;
        ripple   = 1'b1;
        dig      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = val_q[4*k +: 4];
            if (ripple) begin
                if (bus.Up) begin
                    if (dig == 4'd9) begin
                        step_val[4*k +: 4] = 4'd0;
                    end else begin
                        step_val[4*k +: 4] = dig + 4'd1;
                        ripple             = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*k +: 4] = 4'd9;
                    end else begin
                        step_val[4*k +: 4] = dig - 4'd1;
                        ripple             = 1'b0;
                    end
                end
            end
        end
        val_d   = val_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (bus.Clr) begin
            val_d = '0;
            p_d   = '0;
        end else if (tick_ev) begin
            tick_d = 1'b1;
            if (bus.En) begin
                val_d   = step_val;
                carry_d = ripple;
            end
        end
    end

    // Scan path: anode and segments are both registered from i_q, so they always switch together.
    always_comb begin
        s_d       = s_q + 1'b1;
        i_d       = i_q;
        cur_digit = '0;
        anodo_d   = '0;
        if (s_q == SW'(SCAN_DIV - 1)) begin
            s_d = '0;
            i_d = (i_q == IW'(DIGITS - 1)) ? '0 : i_q + 1'b1;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (i_q == IW'(k)) begin
                cur_digit  = val_q[4*k +: 4];
                anodo_d[k] = 1'b1;
            end
        end
        if (ANODE_ACTIVE_LOW) anodo_d = ~anodo_d;
        d_d = seg7(cur_digit);
    end

    always_ff @(posedge C50 or negedge Rst) begin
        if (!Rst) begin
            p_q     <= '0;
            val_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            i_q     <= '0;
            d_q     <= 7'b0000001;
            anodo_q <= AN_RST;
        end else begin
            p_q     <= p_d;
            val_q   <= val_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            i_q     <= i_d;
            d_q     <= d_d;
            anodo_q <= anodo_d;
        end
    end

    assign bus.D     = d_q;
    assign bus.Anodo = anodo_q;
    assign bus.Tick  = tick_q;
    assign bus.Carry = carry_q;
endmodule

// File: tb/tb_contador_bcd_mux.sv
// Bench for contador_bcd_mux: two digits, TICK_DIV=20, SCAN_DIV=10, checked against an integer model.
module tb_contador_bcd_mux;
    localparam int CLK_HZ   = 20;
    localparam int TICK_HZ  = 1;
    localparam int SCAN_HZ  = 1;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int MOD      = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    contador_bcd_mux_if #(.DIGITS(DIGITS)) bus ();

    contador_bcd_mux #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS),
        .SCAN_HZ(SCAN_HZ), .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .C50(clk),
        .Rst(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: integer value, cycles since last clear/reset, edges since reset.
    int         m_val, m_cyc, m_n, m_i;
    bit         m_tick, m_carry;
    logic [6:0] exp_d;
    logic [1:0] exp_an;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic int digit_of(input int v, input int k);
        int p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic logic [1:0] an_of(input int i);
        logic [1:0] a;
        a    = 2'b11;
        a[i] = 1'b0;
        return a;
    endfunction

    task automatic model_reset();
        m_val = 0; m_cyc = 0; m_n = 0; m_i = 0;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare all outputs.
    task automatic step(input bit en, input bit up, input bit clr, input string tag);
        bus.En  = en;
        bus.Up  = up;
        bus.Clr = clr;
        exp_an  = an_of(m_i);
        exp_d   = seg_of(digit_of(m_val, m_i));
        @(posedge clk);
        m_n++;
        m_cyc++;
        m_tick  = 1'b0;
        m_carry = 1'b0;
        if (clr) begin
            m_val = 0;
            m_cyc = 0;
        end else if (m_cyc % TICK_DIV == 0) begin
            m_tick = 1'b1;
            if (en) begin
                if (up) begin
                    m_carry = (m_val == MOD - 1);
                    m_val   = (m_val + 1) % MOD;
                end else begin
                    m_carry = (m_val == 0);
                    m_val   = (m_val + MOD - 1) % MOD;
                end
            end
        end
        m_i = (m_n / SCAN_DIV) % DIGITS;
        #1;
        total++;
        if (bus.D !== exp_d) begin
            bad++;
            $display("FAIL %s D cyc=%0d got=%b exp=%b", tag, m_n, bus.D, exp_d);
        end
        total++;
        if (bus.Anodo !== exp_an) begin
            bad++;
            $display("FAIL %s Anodo cyc=%0d got=%b exp=%b", tag, m_n, bus.Anodo, exp_an);
        end
        total++;
        if (bus.Tick !== m_tick) begin
            bad++;
            $display("FAIL %s Tick cyc=%0d got=%b exp=%b", tag, m_n, bus.Tick, m_tick);
        end
        total++;
        if (bus.Carry !== m_carry) begin
            bad++;
            $display("FAIL %s Carry cyc=%0d got=%b exp=%b", tag, m_n, bus.Carry, m_carry);
        end
    endtask

    task automatic test_reset();
        bus.En = 1'b0; bus.Up = 1'b1; bus.Clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.D !== 7'b0000001 || bus.Anodo !== 2'b10 || bus.Tick !== 1'b0 || bus.Carry !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got D=%b An=%b T=%b C=%b exp D=0000001 An=10 T=0 C=0",
                     bus.D, bus.Anodo, bus.Tick, bus.Carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_count_up();
        int ticks = 0;
        for (int c = 0; c < 21 * TICK_DIV; c++) begin
            step(1'b1, 1'b1, 1'b0, "count_up");
            if (bus.Tick === 1'b1) ticks++;
        end
        total++;
        if (ticks != 21) begin
            bad++;
            $display("FAIL count_up_ticks got=%0d exp=21", ticks);
        end
    endtask

    task automatic test_wrap_up();
        int carries = 0;
        for (int c = 0; c < 79 * TICK_DIV; c++) begin
            step(1'b1, 1'b1, 1'b0, "wrap_up");
            if (bus.Carry === 1'b1) carries++;
        end
        total++;
        if (bus.Carry !== 1'b1) begin
            bad++;
            $display("FAIL wrap_up_last_carry got=%b exp=1", bus.Carry);
        end
        total++;
        if (carries != 1) begin
            bad++;
            $display("FAIL wrap_up_carry_count got=%0d exp=1", carries);
        end
    endtask

    task automatic test_wrap_down();
        for (int c = 0; c < TICK_DIV; c++) step(1'b1, 1'b0, 1'b0, "wrap_down");
        total++;
        if (bus.Carry !== 1'b1) begin
            bad++;
            $display("FAIL borrow_00_to_99 got=%b exp=1", bus.Carry);
        end
        for (int c = 0; c < TICK_DIV; c++) step(1'b1, 1'b0, 1'b0, "wrap_down");
        total++;
        if (bus.Carry !== 1'b0) begin
            bad++;
            $display("FAIL borrow_99_to_98 got=%b exp=0", bus.Carry);
        end
    endtask

    task automatic test_clr_on_tick();
        int wait_cyc = 0;
        bit seen = 1'b0;
        // 98 + 39 ticks lands on 37; direction is flipped between ticks to show it is ignored there.
        for (int c = 0; c < 39 * TICK_DIV; c++)
            step(1'b1, (c % TICK_DIV == TICK_DIV - 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, "to_37");
        for (int c = 0; c < TICK_DIV - 1; c++) step(1'b1, 1'b1, 1'b0, "to_37");
        step(1'b1, 1'b1, 1'b1, "clr_on_tick");
        total++;
        if (bus.Tick !== 1'b0 || bus.Carry !== 1'b0) begin
            bad++;
            $display("FAIL clr_on_tick got T=%b C=%b exp T=0 C=0", bus.Tick, bus.Carry);
        end
        while (!seen && wait_cyc < 2 * TICK_DIV) begin
            step(1'b1, 1'b1, 1'b0, "after_clr");
            wait_cyc++;
            if (bus.Tick === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || wait_cyc != TICK_DIV) begin
            bad++;
            $display("FAIL clr_next_tick got=%0d seen=%0d exp=%0d", wait_cyc, seen, TICK_DIV);
        end
    endtask

    task automatic test_scan();
        int n_units = 0;
        int n_tens  = 0;
        step(1'b0, 1'b1, 1'b1, "scan_clr");
        for (int c = 0; c < 42 * TICK_DIV; c++) step(1'b1, 1'b1, 1'b0, "to_42");
        step(1'b0, 1'b1, 1'b0, "scan_settle");
        for (int c = 0; c < 2 * DIGITS * SCAN_DIV; c++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, "scan");
            if (bus.Anodo === 2'b10 && bus.D === 7'b0010010) n_units++;
            if (bus.Anodo === 2'b01 && bus.D === 7'b1001100) n_tens++;
        end
        total++;
        if (n_units != 2 * SCAN_DIV) begin
            bad++;
            $display("FAIL scan_units_cycles got=%0d exp=%0d", n_units, 2 * SCAN_DIV);
        end
        total++;
        if (n_tens != 2 * SCAN_DIV) begin
            bad++;
            $display("FAIL scan_tens_cycles got=%0d exp=%0d", n_tens, 2 * SCAN_DIV);
        end
    endtask

    task automatic test_async_reset();
        int early = 0;
        step(1'b0, 1'b1, 1'b1, "ar_clr");
        for (int c = 0; c < 57 * TICK_DIV + 7; c++) step(1'b1, 1'b1, 1'b0, "to_57");
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.D !== 7'b0000001 || bus.Anodo !== 2'b10 || bus.Tick !== 1'b0 || bus.Carry !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got D=%b An=%b T=%b C=%b exp D=0000001 An=10 T=0 C=0",
                     bus.D, bus.Anodo, bus.Tick, bus.Carry);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < TICK_DIV - 1; c++) begin
            step(1'b1, 1'b1, 1'b0, "after_rst");
            if (bus.Tick === 1'b1) early++;
        end
        step(1'b1, 1'b1, 1'b0, "after_rst");
        total++;
        if (early != 0 || bus.Tick !== 1'b1) begin
            bad++;
            $display("FAIL first_tick_after_rst got early=%0d tick20=%b exp early=0 tick20=1", early, bus.Tick);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) == 0), "random");
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_clr_on_tick();
        test_scan();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
